uart_program_loader: RTL

//   UART receiver and program loader; the receive-side counterpart of the PC-reporting UART transmitter.

---
 rtl/uart_program_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// 8N1 UART receiver feeding a framed program loader: SYNC_B, 16-bit length, big-endian
// 16-bit words written to BSRAM from address 0, then a mod-256 byte checksum.
module uart_program_loader #(
   parameter int unsigned CLK_HZ = 27_000_000,
   parameter int unsigned BAUD   = 115_200,
   parameter int unsigned ADDR_W = 11,
   parameter logic [7:0]  SYNC_B = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              boot_mode,
   output logic              done,
   output logic              err
);

   localparam int unsigned DIV     = CLK_HZ / BAUD;
   localparam int unsigned HALF    = DIV / 2;
   localparam int unsigned CNT_W   = $clog2(DIV + 1);
   localparam int unsigned MAX_LEN = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] C_DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(HALF - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      LD_SYNC, LD_LEN_HI, LD_LEN_LO, LD_D_HI, LD_D_LO, LD_CSUM, LD_DONE, LD_ERR
   } ld_state_t;

   rx_state_t        r_rx_state, w_rx_next;
   logic             r_sync1, r_sync2, r_prev;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             w_tick, w_byte_valid, w_frame_err;
   logic [7:0]       w_byte;

   ld_state_t        r_ld_state, w_ld_next;
   logic [7:0]       r_len_hi, r_hi, r_sum;
   logic [15:0]      r_remaining;
   logic [15:0]      w_len;
   logic             w_sync_hit, w_write;
   logic             r_we, r_inc, r_boot, r_done, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]      r_din;

   assign w_byte = r_shift;
   assign w_len  = {r_len_hi, w_byte};

   // ---------------- receiver ----------------
   always_comb begin
      w_rx_next    = r_rx_state;
      w_tick       = 1'b0;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (r_prev && !r_sync2) w_rx_next = RX_START;
         RX_START: if (r_cnt == C_HALF_M1) begin
            w_tick    = 1'b1;
            w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA:  if (r_cnt == C_DIV_M1) begin
            w_tick = 1'b1;
            if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
         end
         RX_STOP:  if (r_cnt == C_DIV_M1) begin
            w_tick       = 1'b1;
            w_rx_next    = RX_IDLE;
            w_byte_valid = r_sync2;
            w_frame_err  = !r_sync2;
         end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_prev     <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
      end else begin
         r_sync1    <= uart_rx;
         r_sync2    <= r_sync1;
         r_prev     <= r_sync2;
         r_rx_state <= w_rx_next;
         r_cnt      <= (r_rx_state == RX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
         if (r_rx_state == RX_DATA && w_tick) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
         end
      end
   end

   // ---------------- loader ----------------
   always_comb begin
      w_ld_next  = r_ld_state;
      w_sync_hit = 1'b0;
      w_write    = 1'b0;
      case (r_ld_state)
         LD_SYNC, LD_DONE: if (w_byte_valid && w_byte == SYNC_B) begin
            w_ld_next  = LD_LEN_HI;
            w_sync_hit = 1'b1;
         end
         LD_LEN_HI: if (w_byte_valid) w_ld_next = LD_LEN_LO;
         LD_LEN_LO: if (w_byte_valid)
            w_ld_next = (w_len == 16'd0 || 32'(w_len) > MAX_LEN) ? LD_ERR : LD_D_HI;
         LD_D_HI:   if (w_byte_valid) w_ld_next = LD_D_LO;
         LD_D_LO:   if (w_byte_valid) begin
            w_write   = 1'b1;
            w_ld_next = (r_remaining == 16'd1) ? LD_CSUM : LD_D_HI;
         end
         LD_CSUM:   if (w_byte_valid) w_ld_next = (w_byte == r_sum) ? LD_DONE : LD_ERR;
         LD_ERR:    w_ld_next = LD_SYNC;
         default:   w_ld_next = LD_SYNC;
      endcase
      if (w_frame_err && r_ld_state != LD_SYNC && r_ld_state != LD_DONE)
         w_ld_next = LD_ERR;
   end

   // Address advances one clock after the strobe drops, so it is stable across mem_we.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ld_state  <= LD_SYNC;
         r_len_hi    <= '0;
         r_hi        <= '0;
         r_sum       <= '0;
         r_remaining <= '0;
         r_we        <= 1'b0;
         r_inc       <= 1'b0;
         r_addr      <= '0;
         r_din       <= '0;
         r_boot      <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ld_state <= w_ld_next;
         r_we       <= w_write;
         r_inc      <= r_we;
         if (w_write) r_din <= {r_hi, w_byte};
         if (w_sync_hit) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_sum  <= '0;
            r_boot <= 1'b1;
         end else if (r_inc) begin
            r_addr <= r_addr + 1'b1;
         end
         if (w_byte_valid) begin
            if (r_ld_state == LD_LEN_HI) r_len_hi <= w_byte;
            if (r_ld_state == LD_LEN_LO) r_remaining <= w_len;
            if (r_ld_state == LD_D_HI) begin
               r_hi  <= w_byte;
               r_sum <= r_sum + w_byte;
            end
            if (r_ld_state == LD_D_LO) begin
               r_sum       <= r_sum + w_byte;
               r_remaining <= r_remaining - 1'b1;
            end
         end
         if (w_ld_next == LD_DONE && r_ld_state != LD_DONE) begin
            r_done <= 1'b1;
            r_boot <= 1'b0;
         end
         if (w_ld_next == LD_ERR) begin
            r_err  <= 1'b1;
            r_boot <= 1'b1;
         end
      end
   end

   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_din   = r_din;
   assign boot_mode = r_boot;
   assign done      = r_done;
   assign err       = r_err;

endmodule
